// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the CPU control unit, mem_access_ctrl and the data memory port.
// The err signal exists only when MEM_ACCESS_WRAP_CHECK_EN is defined.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16
);
    localparam int unsigned LEN_W = $clog2(MAX_BURST);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_ACCESS_WRAP_CHECK_EN
    logic              err;

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_rdata,
        input  req_ready, wr_ready, rd_valid, rd_data, done, busy,
               mem_we, mem_addr, mem_wdata, err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_rdata,
        output req_ready, wr_ready, rd_valid, rd_data, done, busy,
               mem_we, mem_addr, mem_wdata, err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_rdata,
        input  req_ready, wr_ready, rd_valid, rd_data, done, busy,
               mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_rdata,
        output req_ready, wr_ready, rd_valid, rd_data, done, busy,
               mem_we, mem_addr, mem_wdata
    );
`endif
endinterface

// File: rtl/mem_access_ctrl.sv
// Burst sequencer driving the single-port data memory for the CPU control unit.
// Optional MEM_ACCESS_WRAP_CHECK_EN rejects bursts that would wrap past the top address.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned RD_WAIT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);
    localparam int unsigned LEN_W  = $clog2(MAX_BURST);
    localparam int unsigned WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [2:0] {IDLE, RD_WAIT_S, RD_CAP, WR_BEAT, FIN} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              req_ready_q, wr_ready_q, busy_q;
    logic              wr_hs;
    logic              wrap_reject;
`ifdef MEM_ACCESS_WRAP_CHECK_EN
    logic              err_pend_q, err_pend_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   end_addr;
`endif

    // Next-state and datapath decode
    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        we_d       = 1'b0;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        wr_hs      = (state_q == WR_BEAT) && wr_ready_q && bus.wr_valid;
`ifdef MEM_ACCESS_WRAP_CHECK_EN
        err_pend_d  = err_pend_q;
        err_d       = 1'b0;
        end_addr    = (ADDR_W+1)'(bus.req_addr) + (ADDR_W+1)'(bus.req_len);
        wrap_reject = end_addr[ADDR_W];
`else
        wrap_reject = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req_valid && wrap_reject) begin
                    state_d = FIN;
`ifdef MEM_ACCESS_WRAP_CHECK_EN
                    err_pend_d = 1'b1;
`endif
                end else if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    beats_d = bus.req_len;
                    wait_d  = WAIT_W'(RD_WAIT - 1);
                    state_d = bus.req_write ? WR_BEAT : RD_WAIT_S;
                end
            end
            RD_WAIT_S: begin
                if (wait_q == '0) begin
                    state_d = RD_CAP;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            RD_CAP: begin
                rdata_d    = bus.mem_rdata;
                rd_valid_d = 1'b1;
                if (beats_q == '0) begin
                    state_d = FIN;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    beats_d = beats_q - LEN_W'(1);
                    wait_d  = WAIT_W'(RD_WAIT - 1);
                    state_d = RD_WAIT_S;
                end
            end
            WR_BEAT: begin
                // Advance only after the previous beat's write cycle has completed
                if (we_q) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (wr_hs) begin
                    wdata_d = bus.wr_data;
                    we_d    = 1'b1;
                    if (beats_q == '0) begin
                        state_d = FIN;
                    end else begin
                        beats_d = beats_q - LEN_W'(1);
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef MEM_ACCESS_WRAP_CHECK_EN
                err_d      = err_pend_q;
                err_pend_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beats_q     <= '0;
            wait_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ACCESS_WRAP_CHECK_EN
            err_pend_q  <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            we_q        <= we_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            req_ready_q <= (state_d == IDLE);
            wr_ready_q  <= (state_d == WR_BEAT);
            busy_q      <= (state_d != IDLE);
`ifdef MEM_ACCESS_WRAP_CHECK_EN
            err_pend_q  <= err_pend_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rdata_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
`ifdef MEM_ACCESS_WRAP_CHECK_EN
    assign bus.err       = err_q;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural memory, spec-level reference model,
// directed scenarios plus randomized bursts.
module tb_mem_access_ctrl;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned RD_WAIT   = 1;
    localparam int unsigned LEN_W     = $clog2(MAX_BURST);
    localparam int          DEPTH     = 1 << ADDR_W;
`ifdef MEM_ACCESS_WRAP_CHECK_EN
    localparam bit WRAP_CHK = 1'b1;
`else
    localparam bit WRAP_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .RD_WAIT(RD_WAIT))
        dut (.clk(clk), .reset(reset), .bus(bus));

    // Memory device (combinational read) and reference image of its contents
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int we_viol = 0;
    logic [ADDR_W+DATA_W-1:0] wq[$];
    logic [DATA_W-1:0]        rq[$];
    int rd_cyc_q[$];
    int done_q[$];
    int acc_q[$];
    int err_q[$];
    logic [DATA_W-1:0] wdata_q[$];
    bit acc_s, hs_s;

    // Monitor: handshakes sampled at the edge, outputs 1 time unit after it
    always @(posedge clk) begin
        acc_s = (bus.req_valid === 1'b1) && (bus.req_ready === 1'b1) && (reset === 1'b0);
        hs_s  = (bus.wr_valid === 1'b1) && (bus.wr_ready === 1'b1) && (reset === 1'b0);
        if (acc_s) acc_q.push_back(cyc);
        cyc++;
        #1;
        if (bus.mem_we !== hs_s) we_viol++;
        if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
        if (bus.rd_valid === 1'b1) begin
            rq.push_back(bus.rd_data);
            rd_cyc_q.push_back(cyc);
        end
        if (bus.done === 1'b1) done_q.push_back(cyc);
`ifdef MEM_ACCESS_WRAP_CHECK_EN
        if (bus.err === 1'b1) err_q.push_back(cyc);
`endif
    end

    function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] a, input int i);
        return ADDR_W'((int'(a) + i) % DEPTH);
    endfunction

    function automatic bit model_exec(input logic [ADDR_W-1:0] a, input int len);
        return !(WRAP_CHK && ((int'(a) + len) > (DEPTH - 1)));
    endfunction

    task automatic drive_beat(input logic [DATA_W-1:0] d);
        bit taken;
        taken = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        for (int t = 0; t < 50 && !taken; t++) begin
            taken = (bus.wr_ready === 1'b1);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        n_vec++;
        if (!taken) begin
            n_err++;
            $display("FAIL wr_beat_timeout: wr_ready never seen, required within 50 cycles");
        end
    endtask

    // Issue one request, feed write beats from wdata_q, wait for done (all bounded)
    task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] a, input int len, input int gap);
        bit acc, fin;
        int d0;
        d0 = done_q.size();
        wq.delete(); rq.delete(); rd_cyc_q.delete(); acc_q.delete();
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_len   = LEN_W'(len);
        bus.req_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            acc = (bus.req_ready === 1'b1);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL req_accept_timeout: req_ready never seen, required within 100 cycles");
        end
        if (acc && wr && model_exec(a, len)) begin
            for (int i = 0; i <= len; i++) begin
                repeat (gap) @(negedge clk);
                drive_beat(wdata_q[i]);
            end
        end
        fin = (done_q.size() > d0);
        for (int t = 0; t < 300 && !fin; t++) begin
            @(negedge clk);
            fin = (done_q.size() > d0);
        end
        n_vec++;
        if (!fin) begin
            n_err++;
            $display("FAIL done_timeout: done count %0d, required %0d", done_q.size(), d0 + 1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.req_ready, bus.busy, bus.wr_ready, bus.rd_valid, bus.done, bus.mem_we} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b required 100000",
                     {bus.req_ready, bus.busy, bus.wr_ready, bus.rd_valid, bus.done, bus.mem_we});
        end
        n_vec++;
        if (bus.mem_addr !== '0) begin
            n_err++; $display("FAIL reset_mem_addr got %h required 00", bus.mem_addr);
        end
        n_vec++;
        if (bus.mem_wdata !== '0) begin
            n_err++; $display("FAIL reset_mem_wdata got %h required 00", bus.mem_wdata);
        end
        n_vec++;
        if (bus.rd_data !== '0) begin
            n_err++; $display("FAIL reset_rd_data got %h required 00", bus.rd_data);
        end
`ifdef MEM_ACCESS_WRAP_CHECK_EN
        n_vec++;
        if (bus.err !== 1'b0) begin
            n_err++; $display("FAIL reset_err got %b required 0", bus.err);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        logic [ADDR_W+DATA_W-1:0] exp_w;
        wdata_q = '{8'hA5};
        run_txn(1'b1, 8'h10, 0, 0);
        ref_mem[8'h10] = 8'hA5;
        exp_w = {8'h10, 8'hA5};
        n_vec++;
        if (wq.size() != 1) begin
            n_err++; $display("FAIL wr1_count got %0d required 1", wq.size());
        end else begin
            n_vec++;
            if (wq[0] !== exp_w) begin
                n_err++; $display("FAIL wr1_beat got %h required %h", wq[0], exp_w);
            end
        end
    endtask

    task automatic test_single_read();
        run_txn(1'b0, 8'h10, 0, 0);
        n_vec++;
        if (rq.size() != 1 || rq[0] !== ref_mem[8'h10]) begin
            n_err++;
            $display("FAIL rd1_data got %0d beats first %h required 1 beat %h",
                     rq.size(), (rq.size() > 0) ? rq[0] : 8'h00, ref_mem[8'h10]);
        end
        n_vec++;
        if (wq.size() != 0) begin
            n_err++; $display("FAIL rd1_no_write got %0d mem_we pulses required 0", wq.size());
        end
        n_vec++;
        if (acc_q.size() != 1 || rd_cyc_q.size() != 1 || rd_cyc_q[0] - acc_q[0] != int'(RD_WAIT) + 2) begin
            n_err++;
            $display("FAIL rd1_rd_latency got %0d required %0d",
                     (acc_q.size() > 0 && rd_cyc_q.size() > 0) ? rd_cyc_q[0] - acc_q[0] : -1,
                     int'(RD_WAIT) + 2);
        end
        n_vec++;
        if (acc_q.size() != 1 || done_q.size() == 0 || done_q[done_q.size()-1] - acc_q[0] != int'(RD_WAIT) + 3) begin
            n_err++;
            $display("FAIL rd1_done_latency got %0d required %0d",
                     (acc_q.size() > 0 && done_q.size() > 0) ? done_q[done_q.size()-1] - acc_q[0] : -1,
                     int'(RD_WAIT) + 3);
        end
    endtask

    task automatic test_burst_gap();
        logic [ADDR_W+DATA_W-1:0] exp_w;
        wdata_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_txn(1'b1, 8'h20, 3, 2);
        n_vec++;
        if (wq.size() != 4) begin
            n_err++; $display("FAIL burst_wr_count got %0d required 4", wq.size());
        end
        for (int i = 0; i < 4; i++) begin
            ref_mem[model_addr(8'h20, i)] = wdata_q[i];
            exp_w = {model_addr(8'h20, i), wdata_q[i]};
            if (i < wq.size()) begin
                n_vec++;
                if (wq[i] !== exp_w) begin
                    n_err++; $display("FAIL burst_wr_%0d got %h required %h", i, wq[i], exp_w);
                end
            end
        end
        run_txn(1'b0, 8'h20, 3, 0);
        n_vec++;
        if (rq.size() != 4) begin
            n_err++; $display("FAIL burst_rd_count got %0d required 4", rq.size());
        end
        for (int i = 0; i < 4 && i < rq.size(); i++) begin
            n_vec++;
            if (rq[i] !== ref_mem[model_addr(8'h20, i)]) begin
                n_err++;
                $display("FAIL burst_rd_%0d got %h required %h", i, rq[i], ref_mem[model_addr(8'h20, i)]);
            end
        end
    endtask

    task automatic test_wrap();
        int e0, d0;
        logic [ADDR_W+DATA_W-1:0] exp_w;
        wdata_q = '{8'h3C, 8'hC3, 8'h5A};
        e0 = err_q.size();
        d0 = done_q.size();
        run_txn(1'b1, 8'hFE, 2, 0);
`ifdef MEM_ACCESS_WRAP_CHECK_EN
        n_vec++;
        if (wq.size() != 0) begin
            n_err++; $display("FAIL wrap_no_write got %0d mem_we pulses required 0", wq.size());
        end
        n_vec++;
        if (err_q.size() != e0 + 1 || done_q.size() != d0 + 1 || err_q[e0] != done_q[d0]) begin
            n_err++;
            $display("FAIL wrap_err got %0d err pulses required 1 coincident with done", err_q.size() - e0);
        end
`else
        n_vec++;
        if (wq.size() != 3 || err_q.size() != e0) begin
            n_err++; $display("FAIL wrap_wr_count got %0d required 3", wq.size());
        end
        for (int i = 0; i < 3; i++) begin
            ref_mem[model_addr(8'hFE, i)] = wdata_q[i];
            exp_w = {model_addr(8'hFE, i), wdata_q[i]};
            if (i < wq.size()) begin
                n_vec++;
                if (wq[i] !== exp_w) begin
                    n_err++; $display("FAIL wrap_wr_%0d got %h required %h", i, wq[i], exp_w);
                end
            end
        end
        run_txn(1'b0, 8'hFE, 2, 0);
        n_vec++;
        if (rq.size() != 3 || rq[0] !== ref_mem[8'hFE] || rq[2] !== ref_mem[8'h00]) begin
            n_err++; $display("FAIL wrap_readback got %0d beats required 3 matching model", rq.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        int d0;
        bit seen;
        wq.delete(); rq.delete();
        d0 = done_q.size();
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h20;
        bus.req_len   = LEN_W'(3);
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = (rq.size() >= 1);
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (!seen || {bus.busy, bus.req_ready, bus.rd_valid, bus.done, bus.mem_we} !== 5'b01000) begin
            n_err++;
            $display("FAIL mid_reset got busy/ready/rd_valid/done/we %b required 01000 (first beat seen %0d)",
                     {bus.busy, bus.req_ready, bus.rd_valid, bus.done, bus.mem_we}, seen);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_vec++;
        if (done_q.size() != d0 || rq.size() != 1) begin
            n_err++;
            $display("FAIL mid_reset_no_done got %0d done %0d beats required 0 done 1 beat",
                     done_q.size() - d0, rq.size());
        end
    endtask

    task automatic test_back_to_back();
        int d0, exp_gap;
        bit got, fin;
        acc_q.delete(); rq.delete();
        d0 = done_q.size();
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h20;
        bus.req_len   = LEN_W'(1);
        bus.req_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = (acc_q.size() >= 2);
        end
        bus.req_valid = 1'b0;
        exp_gap = (int'(RD_WAIT) + 1) * 2 + 2;
        n_vec++;
        if (!got || acc_q[1] - acc_q[0] != exp_gap) begin
            n_err++;
            $display("FAIL b2b_accept_gap got %0d required %0d", got ? acc_q[1] - acc_q[0] : -1, exp_gap);
        end
        n_vec++;
        if (!got || done_q.size() < d0 + 1 || done_q[d0] != acc_q[1]) begin
            n_err++; $display("FAIL b2b_accept_on_done got %0d dones required accept in done cycle", done_q.size() - d0);
        end
        fin = (done_q.size() >= d0 + 2);
        for (int t = 0; t < 100 && !fin; t++) begin
            @(negedge clk);
            fin = (done_q.size() >= d0 + 2);
        end
        n_vec++;
        if (rq.size() != 4) begin
            n_err++; $display("FAIL b2b_rd_count got %0d required 4", rq.size());
        end
        for (int i = 0; i < 4 && i < rq.size(); i++) begin
            n_vec++;
            if (rq[i] !== ref_mem[model_addr(8'h20, i % 2)]) begin
                n_err++;
                $display("FAIL b2b_rd_%0d got %h required %h", i, rq[i], ref_mem[model_addr(8'h20, i % 2)]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        bit wr, ex;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W+DATA_W-1:0] exp_w;
        int len, gap, e0, d0;
        for (int n = 0; n < 24; n++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = (n % 6 == 5) ? ADDR_W'($urandom_range(DEPTH - 4, DEPTH - 1))
                               : ADDR_W'($urandom_range(0, DEPTH - 1));
            len = int'($urandom_range(0, 7));
            gap = int'($urandom_range(0, 2));
            ex  = model_exec(a, len);
            e0  = err_q.size();
            d0  = done_q.size();
            wdata_q.delete();
            for (int i = 0; i <= len; i++) wdata_q.push_back(DATA_W'($urandom));
            run_txn(wr, a, len, gap);
            n_vec++;
            if (done_q.size() != d0 + 1) begin
                n_err++; $display("FAIL rnd%0d_done got %0d pulses required 1", n, done_q.size() - d0);
            end
            n_vec++;
            if (err_q.size() - e0 != (ex ? 0 : 1)) begin
                n_err++; $display("FAIL rnd%0d_err got %0d pulses required %0d", n, err_q.size() - e0, ex ? 0 : 1);
            end
            n_vec++;
            if (wq.size() != ((wr && ex) ? len + 1 : 0)) begin
                n_err++; $display("FAIL rnd%0d_wr_count got %0d required %0d", n, wq.size(), (wr && ex) ? len + 1 : 0);
            end
            n_vec++;
            if (rq.size() != ((!wr && ex) ? len + 1 : 0)) begin
                n_err++; $display("FAIL rnd%0d_rd_count got %0d required %0d", n, rq.size(), (!wr && ex) ? len + 1 : 0);
            end
            for (int i = 0; i <= len; i++) begin
                if (!wr && i < rq.size()) begin
                    n_vec++;
                    if (rq[i] !== ref_mem[model_addr(a, i)]) begin
                        n_err++;
                        $display("FAIL rnd%0d_rd_%0d got %h required %h", n, i, rq[i], ref_mem[model_addr(a, i)]);
                    end
                end
                if (wr && ex) begin
                    exp_w = {model_addr(a, i), wdata_q[i]};
                    ref_mem[model_addr(a, i)] = wdata_q[i];
                    if (i < wq.size()) begin
                        n_vec++;
                        if (wq[i] !== exp_w) begin
                            n_err++; $display("FAIL rnd%0d_wr_%0d got %h required %h", n, i, wq[i], exp_w);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_we_protocol();
        n_vec++;
        if (we_viol != 0) begin
            n_err++; $display("FAIL we_protocol got %0d cycles of mem_we not tied to a handshake, required 0", we_viol);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DATA_W'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_gap();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_we_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the 256x8 single-port data memory: the CPU control unit issues read/write bursts, and this block sequences the memory's address, write-enable and write-data pins.
- Memory read path is combinational (data valid while address held, write_enable low); this block holds the address, waits RD_WAIT cycles, then samples.
- Sits between the control FSM and the memory; the only driver of the memory port.

Parameters:
- ADDR_W, 8, memory address width; depth = 2**ADDR_W.
- DATA_W, 8, data width.
- MAX_BURST, 16, max beats per request; length field width = clog2(MAX_BURST).
- RD_WAIT, 1, cycles address is held before read data sampled (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, accepts request
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  ADDR_W  start address
- req_len  in  clog2(MAX_BURST)  beats minus one (0 = 1 beat)
- wr_valid  in  1  write beat data present
- wr_ready  out  1  write beat accepted this cycle
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DATA_W  read beat data
- done  out  1  one-cycle pulse after last beat
- busy  out  1  request in progress
- mem_we  out  1  to memory write_enable
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory data_in
- mem_rdata  in  DATA_W  from memory data_out

Behaviour:
- Reset: state IDLE; req_ready=1; wr_ready=0; rd_valid=0; done=0; busy=0; mem_we=0; mem_addr=0; mem_wdata=0; rd_data=0; counters 0.
- States: IDLE, RD_WAIT_S, RD_CAP, WR_BEAT, FIN.
- IDLE: req_ready=1. On req_valid: latch addr into mem_addr, beats_left=req_len; go RD_WAIT_S (wait counter=RD_WAIT-1) if read, WR_BEAT if write. busy=1 from next cycle until FIN exits.
- RD_WAIT_S: mem_we=0, mem_addr held; counts down; at 0 go RD_CAP.
- RD_CAP: rd_data<=mem_rdata, rd_valid pulses next cycle. If beats_left=0 go FIN, else mem_addr+1, beats_left-1, back to RD_WAIT_S. Single-beat read with RD_WAIT=1: request accepted cycle 0, rd_valid cycle 3, done cycle 4.
- WR_BEAT: wr_ready=1. On wr_valid&wr_ready: mem_wdata<=wr_data, mem_we=1 for exactly one cycle at current mem_addr; then mem_addr+1 (unless last), beats_left-1. Last beat -> FIN. No wr_valid: wait indefinitely, mem_we=0.
- mem_we never high in any state but the cycle following a WR_BEAT handshake; mem_addr stable while mem_we=1.
- FIN: done=1 one cycle, busy=0, return IDLE; req_ready=1 the following cycle.
- Address increment is modulo 2**ADDR_W (0xFF -> 0x00).
- req_valid ignored while busy; no queueing.
- reset mid-burst: abort immediately, all outputs to reset values next edge; no done pulse; a pending mem_we is dropped.

Optional Feature:
- Macro MEM_ACCESS_WRAP_CHECK_EN.
- Defined: in IDLE, if req_addr+req_len > 2**ADDR_W-1, request is accepted but not executed; err output (1 bit, reset 0) pulses with done one cycle later; no memory access, no wr_ready.
- Undefined: err port absent, wrapping bursts execute with modulo addressing.

Test Plan:
- Write addr 0x10, len 0, wr_data 0xA5 -> one mem_we pulse with mem_addr=0x10, mem_wdata=0xA5; done follows.
- Read back 0x10, len 0 -> rd_valid with rd_data=0xA5, then done; mem_we stays 0.
- Write burst addr 0x20, len 3, data 0x01..0x04 with wr_valid gaps of 2 cycles -> mem_we only on accepted beats, addresses 0x20..0x23; read burst returns 0x01..0x04 in order, 4 rd_valid pulses.
- Write burst addr 0xFE, len 2 -> writes at 0xFE, 0xFF, 0x00 (macro off); with macro on -> err+done, no mem_we.
- Reset asserted during beat 2 of 4-beat read -> next cycle busy=0, req_ready=1, rd_valid=0, no done.
- req_valid held high during busy -> second request accepted only after done, on first req_ready=1 cycle.
